fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port among N_REQ requesters. It grants one requester at a time and allows a burst of up to MAX_BURST beats per grant. It drives the FIFO's write enable and write data, and obeys the FIFO's full flag. It sits directly in front of the shared FIFO instance. Each requester sees a simple req/ack interface.

---
 rtl/fifo_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 76 +++++++
 tb/tb_fifo_wr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and sizing helper for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;
  function automatic int cnt_w(input int max_burst);
    return (max_burst <= 1) ? 1 : $clog2(max_burst);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search of req starting at index start, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // Scan from the far end back toward start so the closest set bit is written last and wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % N]) begin
        gnt                          = '0;
        gnt[(int'(start) + k) % N]   = 1'b1;
        idx                          = IW'((int'(start) + k) % N);
        valid                        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   asrst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       ack,
  output logic                   fifo_wren,
  output logic [WIDTH-1:0]       fifo_wrdata,
  input  logic                   fifo_full,
  output logic [N_REQ-1:0]       cur_gnt,
  output logic                   busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_w(MAX_BURST);
  state_e           r_state, w_state_nx;
  logic [N_REQ-1:0] r_gnt, w_gnt_nx, w_pick;
  logic [IW-1:0]    r_gidx, w_gidx_nx, r_ptr, w_ptr_nx, w_start, w_pick_idx, w_gnext;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             w_valid, w_req_g, w_beat, w_rel;
  assign w_req_g = req[r_gidx];
  assign w_beat  = (r_state == ST_GRANT) && w_req_g && !fifo_full;
  assign w_rel   = (r_state == ST_GRANT) && (!w_req_g || (w_beat && r_cnt == CW'(MAX_BURST - 1)));
  assign w_gnext = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + IW'(1);
  // While granted the search starts just past the holder, so it is only re-picked when alone.
  assign w_start = (r_state == ST_GRANT) ? w_gnext : r_ptr;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .start (w_start),
    .gnt   (w_pick),
    .idx   (w_pick_idx),
    .valid (w_valid)
  );
  assign fifo_wren   = w_beat;
  assign fifo_wrdata = w_beat ? data[int'(r_gidx)*WIDTH +: WIDTH] : '0;
  assign ack         = w_beat ? r_gnt : '0;
  assign cur_gnt     = r_gnt;
  assign busy        = (r_state == ST_GRANT);
  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_gidx_nx  = r_gidx;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    if (r_state == ST_IDLE || w_rel) begin
      w_ptr_nx   = w_rel ? w_gnext : r_ptr;
      w_state_nx = w_valid ? ST_GRANT : ST_IDLE;
      w_gnt_nx   = w_valid ? w_pick : '0;
      w_gidx_nx  = w_pick_idx;
      w_cnt_nx   = '0;
    end else if (w_beat) begin
      w_cnt_nx = r_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge asrst_n) begin
    if (!asrst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_gidx  <= w_gidx_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of the arbiter against a behavioural model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  logic         clk = 1'b0;
  logic         asrst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0] ack, cur_gnt;
  logic         fifo_wren, busy;
  logic         fifo_full = 1'b0;
  logic [W-1:0] fifo_wrdata;
  int checks = 0, errors = 0, wcount = 0;
  int m_g = -1, m_ptr = 0, m_beats = 0;
  logic [W-1:0] d [N];
  logic [N-1:0] s_gnt, s_ack;
  logic         s_wren, s_busy;
  logic [W-1:0] s_wrdata;
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .asrst_n     (asrst_n),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .fifo_wren   (fifo_wren),
    .fifo_wrdata (fifo_wrdata),
    .fifo_full   (fifo_full),
    .cur_gnt     (cur_gnt),
    .busy        (busy)
  );
  always @(negedge clk)
    if (asrst_n === 1'b1 && fifo_wren === 1'b1 && fifo_full === 1'b1) begin
      errors++;
      $display("FAIL wren_while_full: fifo_wren=1 with fifo_full=1 at %0t", $time);
    end
  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction
  // One clock of stimulus: drive, compare against the model, then advance the model on the edge.
  task automatic step();
    logic         e_wren;
    logic [N-1:0] e_gnt, e_ack;
    logic [W-1:0] e_wd;
    int           p;
    for (int i = 0; i < N; i++) data[i*W +: W] = d[i];
    #3;
    e_wren = (m_g >= 0) && req[m_g] && !fifo_full;
    e_gnt  = '0;
    if (m_g >= 0) e_gnt[m_g] = 1'b1;
    e_ack  = e_wren ? e_gnt : '0;
    e_wd   = e_wren ? d[m_g] : '0;
    s_gnt = cur_gnt; s_ack = ack; s_wren = fifo_wren; s_busy = busy; s_wrdata = fifo_wrdata;
    checks += 5;
    if (s_gnt !== e_gnt) begin errors++; $display("FAIL cur_gnt @%0t: got %b want %b", $time, s_gnt, e_gnt); end
    if (s_busy !== (m_g >= 0)) begin errors++; $display("FAIL busy @%0t: got %b want %b", $time, s_busy, m_g >= 0); end
    if (s_wren !== e_wren) begin errors++; $display("FAIL fifo_wren @%0t: got %b want %b", $time, s_wren, e_wren); end
    if (s_ack !== e_ack) begin errors++; $display("FAIL ack @%0t: got %b want %b", $time, s_ack, e_ack); end
    if (s_wrdata !== e_wd) begin errors++; $display("FAIL fifo_wrdata @%0t: got %h want %h", $time, s_wrdata, e_wd); end
    if (s_wren === 1'b1) wcount++;
    @(posedge clk);
    if (m_g < 0) begin
      p = pick(req, m_ptr);
      if (p >= 0) begin m_g = p; m_beats = 0; end
    end else begin
      if (e_wren) begin m_beats++; d[m_g] = d[m_g] + 1'b1; end
      if (!req[m_g] || (e_wren && m_beats == MB)) begin
        m_ptr   = (m_g + 1) % N;
        m_g     = pick(req, m_ptr);
        m_beats = 0;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    asrst_n = 1'b0; req = '0; fifo_full = 1'b0;
    #1;
    m_g = -1; m_ptr = 0; m_beats = 0;
    @(posedge clk);
    #1;
    asrst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    step();
    req = 4'b0010;
    step(); step(); step();
    asrst_n = 1'b0;
    #1;
    checks += 3;
    if (cur_gnt !== 4'b0000) begin errors++; $display("FAIL async_reset_gnt: got %b want 0000", cur_gnt); end
    if (fifo_wren !== 1'b0) begin errors++; $display("FAIL async_reset_wren: got %b want 0", fifo_wren); end
    if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    m_g = -1; m_ptr = 0; m_beats = 0;
    @(posedge clk);
    #1;
    asrst_n = 1'b1;
    req = 4'b0011;
    step(); step();
    checks++;
    if (s_gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", s_gnt); end
  endtask
  task automatic test_single();
    do_reset();
    d[2] = 8'h10;
    req = 4'b0100;
    step();
    wcount = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (s_wrdata !== 8'h14) begin errors++; $display("FAIL regrant_no_bubble_data: got %h want 14", s_wrdata); end
      end
    end
    checks++;
    if (wcount != 9) begin errors++; $display("FAIL single_wren_count: got %0d want 9", wcount); end
  endtask
  task automatic test_all();
    logic [N-1:0] exp_g;
    do_reset();
    req = 4'b1111;
    step();
    wcount = 0;
    for (int k = 0; k < 17; k++) begin
      step();
      if (k % 4 == 0) begin
        exp_g = '0;
        exp_g[(k / 4) % N] = 1'b1;
        checks++;
        if (s_gnt !== exp_g) begin errors++; $display("FAIL rotate_k%0d: got %b want %b", k, s_gnt, exp_g); end
      end
      if (k == 15) begin
        checks++;
        if (wcount != 16) begin errors++; $display("FAIL rotate_wren_count: got %0d want 16", wcount); end
      end
    end
  endtask
  task automatic test_full();
    do_reset();
    req = 4'b0010;
    step();
    wcount = 0;
    step();
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (s_wren !== 1'b0 || s_ack !== 4'b0000 || s_gnt !== 4'b0010) begin
        errors++; $display("FAIL full_hold_k%0d: wren=%b ack=%b gnt=%b want 0 0000 0010", k, s_wren, s_ack, s_gnt);
      end
    end
    fifo_full = 1'b0;
    step(); step(); step();
    checks++;
    if (wcount != 4) begin errors++; $display("FAIL full_burst_count: got %0d want 4", wcount); end
  endtask
  task automatic test_drop();
    do_reset();
    req = 4'b1001;
    step(); step(); step();
    req = 4'b1000;
    step(); step();
    checks++;
    if (s_gnt !== 4'b1000) begin errors++; $display("FAIL drop_regrant: got %b want 1000", s_gnt); end
    req = 4'b0000;
    step();
    req = 4'b0011;
    step(); step();
    checks++;
    if (s_gnt !== 4'b0001) begin errors++; $display("FAIL drop_ptr_wrap: got %b want 0001", s_gnt); end
  endtask
  task automatic test_ptr();
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    req = 4'b0101;
    step(); step();
    checks++;
    if (s_gnt !== 4'b0001) begin errors++; $display("FAIL ptr3_pick: got %b want 0001", s_gnt); end
    req = 4'b0100;
    step(); step();
    checks++;
    if (s_gnt !== 4'b0100) begin errors++; $display("FAIL ptr1_pick: got %b want 0100", s_gnt); end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      fifo_full = ($urandom_range(0, 4) == 0);
      step();
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) d[i] = W'(i * 16);
    #1;
    test_reset();
    test_single();
    test_all();
    test_full();
    test_drop();
    test_ptr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
